// File: rtl/sync_fifo_param_pkg.sv
// Shared definitions for the sync_fifo_param family: width helper,
// wrap-bit pointer comparisons and the transfer/read-mode enumerations.
package sync_fifo_param_pkg;

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_RD   = 2'b01,
        OP_WR   = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    typedef enum logic {
        RD_STD  = 1'b0,
        RD_FWFT = 1'b1
    } rd_mode_e;

    function automatic int clog2_f(input int unsigned n);
        int r;
        int unsigned v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

    function automatic logic ptr_empty(input int unsigned wr, input int unsigned rd);
        return wr == rd;
    endfunction

    // Full: wrap bits differ while the address bits match.
    function automatic logic ptr_full(input int unsigned wr, input int unsigned rd,
                                      input int unsigned addr_w);
        return (wr ^ rd) == (32'd1 << addr_w);
    endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer bus of the FIFO: write/read handshakes plus status flags.
interface sync_fifo_param_if
    import sync_fifo_param_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8
);
    localparam int CNT_W = clog2_f(DEPTH) + 1;

    logic                  write_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  read_en;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [CNT_W-1:0]      data_count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output write_en, data_in, read_en,
        input  data_out, full, empty, almost_full, almost_empty,
               data_count, overflow, underflow
    );

    modport slave (
        input  write_en, data_in, read_en,
        output data_out, full, empty, almost_full, almost_empty,
               data_count, overflow, underflow
    );

endinterface

// File: rtl/sync_fifo_param_ram.sv
// Storage array for sync_fifo_param: one synchronous write port and one
// asynchronous read port; contents are deliberately left unreset.
module sync_fifo_param_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int ADDR_W     = 3
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with wrap-bit pointers, occupancy count, threshold flags,
// sticky error flags, synchronous flush and standard / FWFT read modes.
module sync_fifo_param
    import sync_fifo_param_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int AF_LEVEL   = 6,
    parameter int AE_LEVEL   = 2,
    parameter int FWFT       = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    sync_fifo_param_if.slave  bus
);

    localparam int       ADDR_W = clog2_f(DEPTH);
    localparam int       PTR_W  = ADDR_W + 1;
    localparam rd_mode_e MODE   = (FWFT != 0) ? RD_FWFT : RD_STD;

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      count_q,  count_d;
    logic [DATA_WIDTH-1:0] dout_q,   dout_d;
    logic                  ovf_q,    ovf_d;
    logic                  udf_q,    udf_d;

    logic                  full;
    logic                  empty;
    logic                  wr_acc;
    logic                  rd_acc;
    fifo_op_e              op;
    logic [ADDR_W-1:0]     ram_raddr;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic [DATA_WIDTH-1:0] dout_nxt;

    assign empty  = ptr_empty(32'(wr_ptr_q), 32'(rd_ptr_q));
    assign full   = ptr_full(32'(wr_ptr_q), 32'(rd_ptr_q), ADDR_W);
    assign rd_acc = bus.read_en & ~empty;
    assign wr_acc = bus.write_en & (~full | rd_acc);
    assign op     = fifo_op_e'({wr_acc, rd_acc});

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case (op)
                OP_WR:   count_d = count_q + PTR_W'(1);
                OP_RD:   count_d = count_q - PTR_W'(1);
                default: count_d = count_q;
            endcase
            ovf_d = ovf_q | (bus.write_en & ~wr_acc);
            udf_d = udf_q | (bus.read_en & ~rd_acc);
        end
    end

    // FWFT looks up the word that will be at the head after this edge.
    assign ram_raddr = (MODE == RD_FWFT) ? rd_ptr_d[ADDR_W-1:0] : rd_ptr_q[ADDR_W-1:0];

    sync_fifo_param_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr_q[ADDR_W-1:0]),
        .wr_data (bus.data_in),
        .rd_addr (ram_raddr),
        .rd_data (ram_rdata)
    );

    generate
        if (MODE == RD_FWFT) begin : g_fwft
            logic [DATA_WIDTH-1:0] head;

            // The next head is still in flight when it is the word being written now.
            always_comb begin
                head = ram_rdata;
                if (wr_acc && (rd_ptr_d[ADDR_W-1:0] == wr_ptr_q[ADDR_W-1:0])) begin
                    head = bus.data_in;
                end
            end

            always_comb begin
                dout_nxt = dout_q;
                if (wr_ptr_d != rd_ptr_d) begin
                    dout_nxt = head;
                end
            end
        end else begin : g_std
            always_comb begin
                dout_nxt = dout_q;
                if (rd_acc) begin
                    dout_nxt = ram_rdata;
                end
            end
        end
    endgenerate

    assign dout_d = clear ? '0 : dout_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    assign bus.data_out     = dout_q;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count_q >= PTR_W'(AF_LEVEL));
    assign bus.almost_empty = (count_q <= PTR_W'(AE_LEVEL));
    assign bus.data_count   = count_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: standard and FWFT instances driven in lockstep
// and checked against a queue model, a fill/drain table and corner sequences.
module tb_sync_fifo_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic        we;
    logic        re;
    logic [15:0] din;

    always #5 clk = ~clk;

    sync_fifo_param_if #(.DATA_WIDTH(16), .DEPTH(8)) if_s ();
    sync_fifo_param_if #(.DATA_WIDTH(16), .DEPTH(8)) if_f ();

    assign if_s.write_en = we;
    assign if_s.data_in  = din;
    assign if_s.read_en  = re;
    assign if_f.write_en = we;
    assign if_f.data_in  = din;
    assign if_f.read_en  = re;

    sync_fifo_param #(.DATA_WIDTH(16), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0)) u_std (
        .clk(clk), .reset(reset), .clear(clear), .bus(if_s.slave));

    sync_fifo_param #(.DATA_WIDTH(16), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1)) u_fwft (
        .clk(clk), .reset(reset), .clear(clear), .bus(if_f.slave));

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] sb[$];
    logic        exp_ovf;
    logic        exp_udf;
    logic [15:0] exp_ds;
    logic [15:0] exp_df;

    typedef struct {
        logic        w;
        logic [15:0] d;
        logic        r;
        int          cnt;
        logic        full;
        logic        empty;
        logic        af;
        logic        ae;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic check_all(input string tag);
        int sz;
        sz = sb.size();
        chk({tag, " std count"},  32'(if_s.data_count),   32'(sz));
        chk({tag, " std full"},   32'(if_s.full),         32'(sz == 8));
        chk({tag, " std empty"},  32'(if_s.empty),        32'(sz == 0));
        chk({tag, " std af"},     32'(if_s.almost_full),  32'(sz >= 6));
        chk({tag, " std ae"},     32'(if_s.almost_empty), 32'(sz <= 2));
        chk({tag, " std ovf"},    32'(if_s.overflow),     32'(exp_ovf));
        chk({tag, " std udf"},    32'(if_s.underflow),    32'(exp_udf));
        chk({tag, " std dout"},   32'(if_s.data_out),     32'(exp_ds));
        chk({tag, " fwft count"}, 32'(if_f.data_count),   32'(sz));
        chk({tag, " fwft full"},  32'(if_f.full),         32'(sz == 8));
        chk({tag, " fwft empty"}, 32'(if_f.empty),        32'(sz == 0));
        chk({tag, " fwft ovf"},   32'(if_f.overflow),     32'(exp_ovf));
        chk({tag, " fwft udf"},   32'(if_f.underflow),    32'(exp_udf));
        chk({tag, " fwft dout"},  32'(if_f.data_out),     32'(exp_df));
    endtask

    task automatic model_reset();
        sb.delete();
        exp_ovf = 1'b0;
        exp_udf = 1'b0;
        exp_ds  = 16'h0000;
        exp_df  = 16'h0000;
    endtask

    // One clock: drive, update the queue model at the edge, compare just after.
    task automatic step(input logic w, input logic [15:0] d, input logic r, input logic c,
                        input string tag);
        int sz;
        logic rd_m;
        logic wr_m;
        we = w; din = d; re = r; clear = c;
        @(posedge clk);
        sz   = sb.size();
        rd_m = r && (sz != 0);
        wr_m = w && ((sz != 8) || rd_m);
        if (c) begin
            model_reset();
        end else begin
            if (rd_m) exp_ds = sb.pop_front();
            if (wr_m) sb.push_back(d);
            if (w && !wr_m) exp_ovf = 1'b1;
            if (r && !rd_m) exp_udf = 1'b1;
            if (sb.size() != 0) exp_df = sb[0];
        end
        #1;
        we = 1'b0; re = 1'b0; clear = 1'b0;
        check_all(tag);
    endtask

    initial begin
        reset = 1'b0; clear = 1'b0; we = 1'b0; re = 1'b0; din = 16'h0000;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        reset = 1'b1;

        // Fill 1..8 then drain, with hand-written counts and flags.
        tbl[0]  = '{1'b1, 16'h0001, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{1'b1, 16'h0002, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 16'h0003, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 16'h0004, 1'b0, 4, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 16'h0005, 1'b0, 5, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 16'h0006, 1'b0, 6, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 16'h0007, 1'b0, 7, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 16'h0008, 1'b0, 8, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 16'h0000, 1'b1, 7, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 16'h0000, 1'b1, 6, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 16'h0000, 1'b1, 5, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 16'h0000, 1'b1, 4, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 16'h0000, 1'b1, 3, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 16'h0000, 1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[14] = '{1'b0, 16'h0000, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[15] = '{1'b0, 16'h0000, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].w, tbl[i].d, tbl[i].r, 1'b0, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d std cnt", i),  32'(if_s.data_count),  32'(tbl[i].cnt));
            chk($sformatf("tbl%0d std full", i), 32'(if_s.full),        32'(tbl[i].full));
            chk($sformatf("tbl%0d std emp", i),  32'(if_s.empty),       32'(tbl[i].empty));
            chk($sformatf("tbl%0d std af", i),   32'(if_s.almost_full), 32'(tbl[i].af));
            chk($sformatf("tbl%0d std ae", i),   32'(if_s.almost_empty),32'(tbl[i].ae));
            chk($sformatf("tbl%0d fwft cnt", i), 32'(if_f.data_count),  32'(tbl[i].cnt));
            chk($sformatf("tbl%0d fwft af", i),  32'(if_f.almost_full), 32'(tbl[i].af));
        end
        chk("drain last std word", 32'(if_s.data_out), 32'h0008);

        // Three complete fill/drain passes across pointer wrap.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 8; i++) step(1'b1, 16'(16'h1000 * (k + 1) + i), 1'b0, 1'b0, "wrap wr");
            for (int i = 0; i < 8; i++) step(1'b0, 16'h0000, 1'b1, 1'b0, "wrap rd");
        end

        // Full with simultaneous read and write.
        for (int i = 0; i < 8; i++) step(1'b1, 16'(16'h0A00 + i), 1'b0, 1'b0, "fs fill");
        step(1'b1, 16'hAAAA, 1'b1, 1'b0, "fs both");
        chk("fs std oldest", 32'(if_s.data_out), 32'h0A00);
        chk("fs fwft head", 32'(if_f.data_out), 32'h0A01);
        chk("fs count", 32'(if_s.data_count), 32'd8);
        chk("fs full", 32'(if_s.full), 32'd1);
        chk("fs ovf", 32'(if_s.overflow), 32'd0);
        for (int i = 0; i < 8; i++) step(1'b0, 16'h0000, 1'b1, 1'b0, "fs drain");
        chk("fs last word", 32'(if_s.data_out), 32'hAAAA);

        // Error flags and clear.
        for (int i = 0; i < 8; i++) step(1'b1, 16'(16'h0B00 + i), 1'b0, 1'b0, "err fill");
        step(1'b1, 16'h5555, 1'b0, 1'b0, "err ovf");
        chk("err ovf set", 32'(if_s.overflow), 32'd1);
        chk("err fwft head kept", 32'(if_f.data_out), 32'h0B00);
        for (int i = 0; i < 8; i++) step(1'b0, 16'h0000, 1'b1, 1'b0, "err drain");
        chk("err last word", 32'(if_s.data_out), 32'h0B07);
        step(1'b0, 16'h0000, 1'b1, 1'b0, "err udf");
        chk("err udf set", 32'(if_s.underflow), 32'd1);
        step(1'b1, 16'h7777, 1'b1, 1'b0, "empty both");
        chk("empty both count", 32'(if_s.data_count), 32'd1);
        step(1'b1, 16'h9999, 1'b1, 1'b1, "clear");
        chk("clear ovf", 32'(if_f.overflow), 32'd0);
        chk("clear udf", 32'(if_f.underflow), 32'd0);
        chk("clear empty", 32'(if_f.empty), 32'd1);
        chk("clear dout", 32'(if_s.data_out), 32'd0);

        // FWFT shows a word written into an empty FIFO on the next cycle.
        step(1'b1, 16'h1234, 1'b0, 1'b0, "fwft lat");
        chk("fwft lat dout", 32'(if_f.data_out), 32'h1234);
        chk("fwft lat empty", 32'(if_f.empty), 32'd0);
        chk("std lat dout", 32'(if_s.data_out), 32'h0000);
        step(1'b0, 16'h0000, 1'b1, 1'b0, "std lat rd");
        chk("std read dout", 32'(if_s.data_out), 32'h1234);

        // Asynchronous reset in the middle of a burst.
        for (int i = 0; i < 3; i++) step(1'b1, 16'(16'hC000 + i), 1'b0, 1'b0, "burst");
        we = 1'b1; din = 16'hC003;
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        chk("areset std empty", 32'(if_s.empty), 32'd1);
        chk("areset std full", 32'(if_s.full), 32'd0);
        chk("areset std count", 32'(if_s.data_count), 32'd0);
        chk("areset fwft dout", 32'(if_f.data_out), 32'd0);
        chk("areset fwft count", 32'(if_f.data_count), 32'd0);
        we = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 80; i++) begin
            step(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 29) == 0), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
